// File: rtl/inst_line_refill.sv
// I-cache line refill engine: turns a cache miss into one 8-beat AXI INCR read
// burst and assembles the returned words into a 256-bit line.
module inst_line_refill #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cache_inst_req,
  input  logic                      cache_inst_wr,
  input  logic [1:0]                cache_inst_size,
  input  logic [31:0]               cache_inst_addr,
  input  logic [31:0]               cache_inst_wdata,
  output logic [32*LINE_WORDS-1:0]  cache_inst_rdata,
  output logic                      cache_inst_addr_ok,
  output logic                      cache_inst_data_ok,
  output logic [3:0]                arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [1:0]                fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [26:0] line_addr;
  logic [2:0]  beat_cnt;

  // Writes are never issued and error responses are stored as ordinary data.
  logic unused_inputs;
  assign unused_inputs = ^{cache_inst_wr, cache_inst_size, cache_inst_wdata, rresp};

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the AR fields are held constant from arvalid rising until arready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      line_addr          <= '0;
      beat_cnt           <= '0;
      cache_inst_rdata   <= '0;
      arvalid            <= 1'b0;
      rready             <= 1'b0;
      cache_inst_data_ok <= 1'b0;
    end else begin
      cache_inst_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (cache_inst_req) begin
            line_addr <= cache_inst_addr[31:5];
            beat_cnt  <= '0;
            arvalid   <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD;
          end
        end
        RD: begin
          if (rvalid) begin
            // Beats for another ID are drained but must not disturb the line.
            if (rid == AXI_ID) begin
              cache_inst_rdata[{beat_cnt, 5'd0} +: 32] <= rdata;
              beat_cnt <= beat_cnt + 3'd1;
            end
            if (rlast) begin
              rready             <= 1'b0;
              cache_inst_data_ok <= 1'b1;
              state              <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cache_inst_addr_ok = (state == IDLE) && cache_inst_req;
  assign araddr             = {line_addr, 5'd0};
  assign arid               = arvalid ? AXI_ID  : 4'd0;
  assign arlen              = arvalid ? 8'd7    : 8'd0;
  assign arsize             = arvalid ? 3'b010  : 3'b000;
  assign arburst            = arvalid ? 2'b01   : 2'b00;
  assign fsm_state          = state;

endmodule

// File: tb/tb_inst_line_refill.sv
// Directed bench for inst_line_refill: a transaction-phase model checks every
// cycle, and each scenario also pins a few hand-computed literals.
module tb_inst_line_refill;

  localparam logic [3:0] AXI_ID = 4'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cache_inst_req = 1'b0;
  logic         cache_inst_wr = 1'b0;
  logic [1:0]   cache_inst_size = 2'd0;
  logic [31:0]  cache_inst_addr = '0;
  logic [31:0]  cache_inst_wdata = '0;
  logic [255:0] cache_inst_rdata;
  logic         cache_inst_addr_ok;
  logic         cache_inst_data_ok;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [3:0]   rid = '0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [1:0]   fsm_state;

  inst_line_refill #(.AXI_ID(AXI_ID), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .cache_inst_req(cache_inst_req), .cache_inst_wr(cache_inst_wr),
    .cache_inst_size(cache_inst_size), .cache_inst_addr(cache_inst_addr),
    .cache_inst_wdata(cache_inst_wdata), .cache_inst_rdata(cache_inst_rdata),
    .cache_inst_addr_ok(cache_inst_addr_ok), .cache_inst_data_ok(cache_inst_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .fsm_state(fsm_state)
  );

  // Clock/reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: phases of the one outstanding refill plus the line contents.
  logic [255:0] exp_q[$];
  logic [255:0] model_line = '0;
  logic [31:0]  exp_addr = '0;
  logic [2:0]   mb = '0;
  bit ar_ph = 0, rd_ph = 0, done_ph = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit busy, nd;
      busy = ar_ph || rd_ph || done_ph;
      check("line_hold", cache_inst_rdata, model_line);
      check("addr_ok", cache_inst_addr_ok, cache_inst_req && !busy);
      check("arvalid", arvalid, ar_ph);
      check("rready", rready, rd_ph);
      check("data_ok", cache_inst_data_ok, done_ph);
      if (arvalid) begin
        check("ar_fields", {arid, arlen, arsize, arburst}, {AXI_ID, 8'd7, 3'b010, 2'b01});
        check("araddr", araddr, exp_addr);
      end
      if (cache_inst_data_ok) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_line: got data_ok with no completed burst expected");
        end else check("done_line", cache_inst_rdata, exp_q.pop_front());
      end
      if (rst) begin
        ar_ph = 0; rd_ph = 0; done_ph = 0; model_line = '0; mb = '0;
        exp_q.delete();
      end else begin
        nd = 0;
        if (cache_inst_req && !busy) begin
          exp_addr = {cache_inst_addr[31:5], 5'd0};
          ar_ph = 1; mb = '0;
        end else if (ar_ph && arready) begin
          ar_ph = 0; rd_ph = 1;
        end else if (rd_ph && rvalid) begin
          if (rid == AXI_ID) begin
            model_line[int'(mb)*32 +: 32] = rdata;
            mb = mb + 3'd1;
          end
          if (rlast) begin
            rd_ph = 0; nd = 1;
            exp_q.push_back(model_line);
          end
        end
        done_ph = nd;
      end
    end
  end

  // Driver: issues one request and plays the AXI slave until data_ok or abort.
  task automatic run_line(input logic [31:0] addr, input logic [31:0] base,
                          input int ar_delay, input bit gap, input bit bad_id,
                          input int abort_beat, input bit hold_req,
                          output int lat, output logic [31:0] ar_seen);
    int cyc, k, arv_cnt;
    bit bad_done, fin, use_bad;
    cyc = 0; k = 0; arv_cnt = 0; bad_done = 0; fin = 0; lat = -1; ar_seen = '0;
    @(posedge clk); #1;
    cache_inst_req   = 1'b1;
    cache_inst_addr  = addr;
    cache_inst_wr    = 1'($urandom_range(0, 1));
    cache_inst_size  = 2'($urandom_range(0, 3));
    cache_inst_wdata = $urandom;
    while (!fin) begin
      arready = (arv_cnt >= ar_delay);
      if (abort_beat >= 0 && k == abort_beat) rst = 1'b1;
      use_bad = bad_id && k == 3 && !bad_done;
      rvalid  = (k < 8) && !(gap && (cyc % 2 == 1));
      rid     = use_bad ? (AXI_ID ^ 4'd1) : AXI_ID;
      rdata   = use_bad ? 32'hDEAD_BEEF : base + 32'(k);
      rresp   = 2'(k % 4);
      rlast   = (k == 7) && !use_bad;
      @(negedge clk);
      if (arvalid) begin
        arv_cnt++;
        if (arready) ar_seen = araddr;
      end
      if (rst) fin = 1;
      else if (rvalid && rready) begin
        if (rid == AXI_ID) k++;
        else bad_done = 1;
      end
      if (cache_inst_data_ok) begin lat = cyc; fin = 1; end
      if (!fin && cyc >= 200) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: no data_ok after %0d cycles, required one", cyc);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
        if (!hold_req) cache_inst_req = 1'b0;
      end
    end
    if (rst) begin
      @(posedge clk); #1;
      rst = 1'b0; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0; cache_inst_req = 1'b0;
    end
  endtask

  int lat;
  logic [31:0] ar_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok, arvalid, rready,
           araddr, arlen, arid, arsize, arburst, fsm_state}, '0);
    chk_en = 1'b1;

    // Basic refill, everything ready
    run_line(32'hBFC0_0014, 32'h100, 0, 0, 0, -1, 0, lat, ar_seen);
    check("t1_latency", lat, 10);
    check("t1_araddr", ar_seen, 32'hBFC0_0000);
    for (int i = 0; i < 8; i++) check("t1_word", cache_inst_rdata[i*32 +: 32], 32'h100 + i);

    // arready held low for 5 arvalid cycles
    run_line(32'h1234_5678, 32'h200, 5, 0, 0, -1, 0, lat, ar_seen);
    check("t2_latency", lat, 15);
    check("t2_araddr", ar_seen, 32'h1234_5660);

    // rvalid on alternate cycles
    run_line(32'h0000_1000, 32'h300, 0, 1, 0, -1, 0, lat, ar_seen);
    check("t3_word0", cache_inst_rdata[31:0], 32'h300);
    check("t3_word7", cache_inst_rdata[255:224], 32'h307);

    // foreign-ID beat before beat 3
    run_line(32'h0000_2000, 32'h400, 0, 0, 1, -1, 0, lat, ar_seen);
    check("t4_latency", lat, 11);
    check("t4_word3", cache_inst_rdata[127:96], 32'h403);

    // reset during beat 4, then a fresh refill
    run_line(32'h0000_3000, 32'h500, 0, 0, 0, 4, 0, lat, ar_seen);
    repeat (3) @(negedge clk);
    check("t5_cleared", {cache_inst_rdata, cache_inst_data_ok}, '0);
    run_line(32'h0000_0040, 32'h600, 0, 0, 0, -1, 0, lat, ar_seen);
    check("t5_araddr", ar_seen, 32'h0000_0040);
    check("t5_latency", lat, 10);
    check("t5_word5", cache_inst_rdata[191:160], 32'h605);

    // back-to-back with req held high
    run_line(32'h8000_0020, 32'h700, 0, 0, 0, -1, 1, lat, ar_seen);
    check("t6a_latency", lat, 10);
    run_line(32'h8000_0100, 32'h800, 0, 0, 0, -1, 0, lat, ar_seen);
    check("t6b_latency", lat, 10);
    check("t6b_araddr", ar_seen, 32'h8000_0100);
    check("t6b_word6", cache_inst_rdata[223:192], 32'h806);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
